fetch_stage: RTL
================

# fetch_stage

Instruction-fetch stage of the pipelined MIPS core, directly upstream of decode. Owns the fetch PC (PCF), drives a variable-latency instruction-memory request/ready handshake, and loads the IF/ID pipeline register (InstrD, PCPlus4D) that feeds the controller and decode datapath. It applies decode-stage redirects (branch via PCSrcD, jump via JumpD) and honours hazard-unit stalls. Cycles where memory has not yet answered become decode bubbles.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- clk  in  1  pipeline clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low reset.
- StallF  in  1  hazard unit: hold PCF; deassert imem_req.
- StallD  in  1  hazard unit: hold IF/ID register; redirect inputs ignored.
- PCSrcD  in  1  taken branch resolved in decode.
- PCBranchD  in  32  branch target.
- JumpD  in  1  jump in decode; target = {PCPlus4D[31:28], InstrD[25:0], 2'b00}.
- imem_req  out  1  fetch request valid.
- imem_addr  out  32  fetch address (= PCF); stable while imem_req && !imem_ready.
- imem_ready  in  1  transfer completes on imem_req && imem_ready.
- imem_rdata  in  32  instruction; valid in the transfer cycle.
- PCF  out  32  current fetch PC.
- InstrD  out  32  IF/ID instruction; 32'h0 (nop) on bubble.
- PCPlus4D  out  32  IF/ID PC+4.
- ValidD  out  1  IF/ID holds a real instruction.
- FetchBusy  out  1  imem_req && !imem_ready (status for the hazard unit and performance counters).

## Operation
- FSM states: FETCH, WAIT, DROP. Reset enters FETCH.
- FETCH/WAIT:
  - imem_req = !StallF.
  - Transfer without StallD: InstrD <= imem_rdata, PCPlus4D <= PCF+4, ValidD <= 1, PCF <= next PC, state FETCH.
  - No transfer and !StallD: IF/ID loads bubble (InstrD=0, ValidD=0); state WAIT.
- StallF and StallD are always equal, as guaranteed by the hazard unit. A transfer cannot coincide with StallD because imem_req is low.
- Redirect = ValidD && !StallD && (PCSrcD || JumpD). JumpD has priority over PCSrcD if both are set. Target is latched in RedirPC.
- Redirect, non-delay-slot mode (see Configuration):
  - Transfer in the same cycle: data discarded, IF/ID <= bubble, PCF <= target.
  - Request outstanding (imem_req && !imem_ready): go to DROP and keep imem_addr unchanged.
- DROP: imem_req = 1 at the old address. On imem_ready, discard the data, insert a bubble, set PCF <= RedirPC, and go to FETCH.
- Next PC = pending redirect target if one is pending, else PCF+4. Adds are modulo 2^32; PCF+4 from 32'hFFFF_FFFC wraps to 0.
- Reset (any state, including mid-request):
  - PCF=RESET_PC, InstrD=0, PCPlus4D=0, ValidD=0, imem_req=0, FetchBusy=0.
  - Pending redirect cleared; state FETCH.
  - The outstanding request is abandoned. Imem is reset by the same reset.

## Timing
- Zero-wait memory: one instruction per cycle. Transfer at edge N makes InstrD valid in cycle N+1.
- Memory latency L cycles gives L-1 bubbles.
- imem_req is first asserted in the first cycle after reset deasserts.
- Redirect penalty, zero-wait memory, no delay slot: one bubble; target is fetched in the cycle after the redirect.
- Redirect with request outstanding: bubbles until old response returns, then one more fetch at the target.
- Redirect evaluated only when StallD=0. A stalled branch is re-evaluated each cycle until StallD drops.

## Configuration
- FETCH_DELAY_SLOT_EN defined:
  - The instruction at PCF when the redirect is seen is the architectural delay slot and enters IF/ID normally.
  - RedirPC is applied as next PC after that instruction transfers; DROP is never entered.
- Not defined: wrong-path instruction squashed as described in Operation.

## Test plan
- Reset with RESET_PC=32'h0000_0100, zero-wait imem → imem_addr 0x100, 0x104, 0x108 on consecutive cycles; ValidD=1 from the second cycle.
- imem_ready low 2 cycles per fetch → two bubbles (InstrD=0, ValidD=0) between instructions; FetchBusy high during waits.
- Branch at 0x100 taken to 0x200 (PCSrcD=1), zero-wait, no delay slot → 0x104 squashed, next valid PCPlus4D=0x204. With FETCH_DELAY_SLOT_EN: 0x104 valid, then 0x200.
- Jump decoded while fetch of 0x108 outstanding 3 cycles → imem_addr held 0x108 until ready, data dropped, then 0x0040_0000 target fetched.
- StallF=StallD=1 for 3 cycles → imem_req=0, PCF, InstrD, ValidD unchanged; PCSrcD during stall ignored.
- Reset asserted mid-WAIT at PCF=0x300 → next cycle PCF=RESET_PC, ValidD=0, imem_req=0; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_stage.sv
// fetch_stage: MIPS fetch PC, imem request/ready handshake and IF/ID pipeline register.
// Define FETCH_DELAY_SLOT_EN to let the instruction after a branch/jump execute as a delay slot.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        StallF_i,
    input  logic        StallD_i,
    input  logic        PCSrcD_i,
    input  logic [31:0] PCBranchD_i,
    input  logic        JumpD_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ready_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] PCF_o,
    output logic [31:0] InstrD_o,
    output logic [31:0] PCPlus4D_o,
    output logic        ValidD_o,
    output logic        FetchBusy_o
);
    typedef enum logic [1:0] {FETCH, WAIT, DROP} state_e;

    state_e      state_q;
    logic [31:0] pc_q, instr_q, pcp4_q, redir_pc_q;
    logic        valid_q, pend_q;
    logic [31:0] pc_plus4, pc_d, target;
    logic        xfer, redirect;

    assign imem_req_o  = reset_i && (state_q == DROP || !StallF_i);
    assign xfer        = imem_req_o && imem_ready_i;
    assign redirect    = valid_q && !StallD_i && (PCSrcD_i || JumpD_i);
    assign target      = JumpD_i ? {pcp4_q[31:28], instr_q[25:0], 2'b00} : PCBranchD_i;
    assign pc_plus4    = pc_q + 32'd4;
    assign pc_d        = pend_q ? redir_pc_q : pc_plus4;
    assign imem_addr_o = pc_q;
    assign PCF_o       = pc_q;
    assign InstrD_o    = instr_q;
    assign PCPlus4D_o  = pcp4_q;
    assign ValidD_o    = valid_q;
    assign FetchBusy_o = imem_req_o && !imem_ready_i;

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state_q    <= FETCH;
            pc_q       <= RESET_PC;
            instr_q    <= '0;
            pcp4_q     <= '0;
            valid_q    <= 1'b0;
            redir_pc_q <= '0;
            pend_q     <= 1'b0;
        end else if (state_q == DROP) begin
            // wrong-path response is swallowed; decode sees bubbles until it returns
            instr_q <= '0;
            valid_q <= 1'b0;
            if (imem_ready_i) begin
                pc_q    <= pc_d;
                pend_q  <= 1'b0;
                state_q <= FETCH;
            end
        end else if (redirect) begin
`ifdef FETCH_DELAY_SLOT_EN
            if (xfer) begin
                instr_q <= imem_rdata_i;
                pcp4_q  <= pc_plus4;
                valid_q <= 1'b1;
                pc_q    <= target;
                state_q <= FETCH;
            end else begin
                instr_q    <= '0;
                valid_q    <= 1'b0;
                redir_pc_q <= target;
                pend_q     <= 1'b1;
                state_q    <= WAIT;
            end
`else
            instr_q <= '0;
            valid_q <= 1'b0;
            if (xfer) begin
                pc_q    <= target;
                state_q <= FETCH;
            end else begin
                redir_pc_q <= target;
                pend_q     <= 1'b1;
                state_q    <= DROP;
            end
`endif
        end else if (xfer) begin
            instr_q <= imem_rdata_i;
            pcp4_q  <= pc_plus4;
            valid_q <= 1'b1;
            pc_q    <= pc_d;
            pend_q  <= 1'b0;
            state_q <= FETCH;
        end else if (!StallD_i) begin
            instr_q <= '0;
            valid_q <= 1'b0;
            state_q <= WAIT;
        end
    end
endmodule
